// File: rtl/picobello_pkg.sv
// Shared Picobello constants and the wake-up sequencer state type.
package picobello_pkg;

  localparam int unsigned NumClusterTiles = 16;
  localparam int unsigned NrCoresPerTile  = 9;

  typedef enum logic [1:0] {
    WakeIdle  = 2'd0,
    WakeRaise = 2'd1,
    WakeGap   = 2'd2,
    WakeDrain = 2'd3
  } wakeup_state_e;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter; MODE 0 counts trailing zeros (find-first-one).
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  logic [WIDTH-1:0] in_sel;

  // Reverse the input for leading-zero mode so one trailing search serves both.
  always_comb begin
    in_sel = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      in_sel[i] = MODE ? in_i[int'(WIDTH) - 1 - i] : in_i[i];
    end
  end

  // Scan from the top so the lowest set index wins.
  always_comb begin
    cnt_o = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (in_sel[i]) cnt_o = CNT_WIDTH'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/picobello_wakeup_seq.sv
// Staggered cluster wake-up: raise msip per cluster with a gap, then drain acks.
module picobello_wakeup_seq
  import picobello_pkg::*;
#(
  parameter int unsigned NumClusters = NumClusterTiles,
  parameter int unsigned NrCores     = NrCoresPerTile,
  parameter int unsigned GapW        = 8,
  parameter int unsigned TimeoutW    = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic [NumClusters-1:0]           cmd_mask_i,
  input  logic [GapW-1:0]                  cmd_gap_i,
  input  logic [TimeoutW-1:0]              cmd_timeout_i,
  input  logic [NumClusters*NrCores-1:0]   msip_clr_i,
  output logic [NumClusters*NrCores-1:0]   msip_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic [$clog2(NumClusters)-1:0]   err_cluster_o
);

  localparam int unsigned NumHarts = NumClusters * NrCores;
  localparam int unsigned ClW      = $clog2(NumClusters);
  localparam int unsigned CntW     = (GapW > TimeoutW) ? GapW : TimeoutW;

  wakeup_state_e state_q, state_d;

  logic [NumClusters-1:0] rem_q, rem_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic [TimeoutW-1:0]    timeout_q, timeout_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NumHarts-1:0]    msip_d, msip_kept;
  logic                   done_d, busy_d, err_d;
  logic [ClW-1:0]         err_cluster_d;

  logic                   handshake;
  logic                   timeout_hit;
  logic [NumClusters-1:0] pending_cl;
  logic [NumClusters-1:0] lzc_in;
  logic [NumClusters-1:0] sel_vec;
  logic [ClW-1:0]         lzc_cnt;
  logic                   lzc_empty;

  assign cmd_ready_o = (state_q == WakeIdle);
  assign handshake   = cmd_valid_i & cmd_ready_o;
  assign msip_kept   = msip_o & ~msip_clr_i;
  assign timeout_hit = (timeout_q != '0) &&
                       (cnt_q == CntW'(timeout_q - TimeoutW'(1)));

  // Clusters that still hold a pending hart once this cycle's clears apply.
  always_comb begin
    pending_cl = '0;
    for (int c = 0; c < int'(NumClusters); c++) begin
      pending_cl[c] = |msip_kept[c*NrCores +: NrCores];
    end
  end

  // One search serves both the raise order and the timeout error cluster.
  always_comb begin
    unique case (state_q)
      WakeIdle:  lzc_in = cmd_mask_i;
      WakeDrain: lzc_in = pending_cl;
      default:   lzc_in = rem_q;
    endcase
  end

  lzc #(
    .WIDTH (NumClusters),
    .MODE  (1'b0)
  ) i_lzc (
    .in_i    (lzc_in),
    .cnt_o   (lzc_cnt),
    .empty_o (lzc_empty)
  );

  assign sel_vec = lzc_empty ? '0 : (NumClusters'(1) << lzc_cnt);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= WakeIdle;
    else       state_q <= state_d;
  end

  // Next-state decode; entering or staying in RAISE is what fires a cluster.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WakeIdle: begin
        if (handshake && (cmd_mask_i != '0)) state_d = WakeRaise;
      end
      WakeRaise: begin
        if (rem_q == '0)       state_d = WakeDrain;
        else if (gap_q != '0)  state_d = WakeGap;
        else                   state_d = WakeRaise;
      end
      WakeGap: begin
        if (cnt_q == '0) state_d = WakeRaise;
      end
      WakeDrain: begin
        if ((msip_o == '0) || timeout_hit) state_d = WakeIdle;
      end
      default: state_d = WakeIdle;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    msip_d        = msip_kept;
    rem_d         = rem_q;
    gap_d         = gap_q;
    timeout_d     = timeout_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    err_d         = err_o;
    err_cluster_d = err_cluster_o;

    // Raise beats a same-cycle clear so an early ack cannot swallow the wake-up.
    if (state_d == WakeRaise) begin
      rem_d = lzc_in & ~sel_vec;
      for (int c = 0; c < int'(NumClusters); c++) begin
        msip_d[c*NrCores +: NrCores] = msip_kept[c*NrCores +: NrCores] |
                                       {NrCores{sel_vec[c]}};
      end
    end

    unique case (state_q)
      WakeIdle: begin
        if (handshake) begin
          gap_d     = cmd_gap_i;
          timeout_d = cmd_timeout_i;
          err_d     = 1'b0;
          if (cmd_mask_i == '0) done_d = 1'b1;
        end
      end
      WakeRaise: begin
        if (state_d == WakeGap)   cnt_d = CntW'(gap_q - GapW'(1));
        if (state_d == WakeDrain) cnt_d = '0;
      end
      WakeGap: begin
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      end
      WakeDrain: begin
        if (msip_o == '0) begin
          done_d = 1'b1;
        end else if (timeout_hit) begin
          done_d = 1'b1;
          // A clear landing on the timeout cycle still counts as success.
          if (msip_kept != '0) begin
            err_d         = 1'b1;
            err_cluster_d = lzc_cnt;
            msip_d        = '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase

    busy_d = (state_d != WakeIdle) | done_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      msip_o        <= '0;
      rem_q         <= '0;
      gap_q         <= '0;
      timeout_q     <= '0;
      cnt_q         <= '0;
      done_o        <= 1'b0;
      busy_o        <= 1'b0;
      err_o         <= 1'b0;
      err_cluster_o <= '0;
    end else begin
      msip_o        <= msip_d;
      rem_q         <= rem_d;
      gap_q         <= gap_d;
      timeout_q     <= timeout_d;
      cnt_q         <= cnt_d;
      done_o        <= done_d;
      busy_o        <= busy_d;
      err_o         <= err_d;
      err_cluster_o <= err_cluster_d;
    end
  end

endmodule

// File: tb/tb_picobello_wakeup_seq.sv
// Bench for the wake-up sequencer: directed scenarios plus random commands
// checked against a schedule-based reference model.
module tb_picobello_wakeup_seq;

  localparam int NC = 16;
  localparam int NR = 9;
  localparam int H  = NC * NR;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [NC-1:0] cmd_mask = '0;
  logic [7:0]    cmd_gap = '0;
  logic [15:0]   cmd_timeout = '0;
  logic [H-1:0]  msip_clr = '0;
  logic [H-1:0]  msip;
  logic          busy, done, err;
  logic [3:0]    err_cluster;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: command schedule expressed in absolute edge numbers.
  int           edge_no = 0;
  bit           m_active = 0;
  int           m_h, m_g, m_to;
  int           m_sel[$];
  logic [H-1:0] m_msip = '0;
  logic         m_done = 0, m_busy = 0, m_err = 0;
  logic [3:0]   m_errcl = '0;

  always #5 clk = ~clk;

  picobello_wakeup_seq dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_mask_i    (cmd_mask),
    .cmd_gap_i     (cmd_gap),
    .cmd_timeout_i (cmd_timeout),
    .msip_clr_i    (msip_clr),
    .msip_o        (msip),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .err_cluster_o (err_cluster)
  );

  function automatic logic [H-1:0] cl_bits(input int c);
    logic [H-1:0] v;
    v = '0;
    v[c*NR +: NR] = '1;
    return v;
  endfunction

  function automatic int lowest_pending(input logic [H-1:0] v);
    for (int c = 0; c < NC; c++) if (|v[c*NR +: NR]) return c;
    return 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [H-1:0] nm;
    int d0;
    nm     = m_msip & ~msip_clr;
    m_done = 0;
    if (rst) begin
      m_active = 0; m_busy = 0; m_err = 0; m_errcl = '0; nm = '0;
    end else if (m_active) begin
      for (int i = 0; i < m_sel.size(); i++)
        if (edge_no == m_h + i * (m_g + 1)) nm |= cl_bits(m_sel[i]);
      d0 = m_h + (m_sel.size() - 1) * (m_g + 1) + 2;
      if (edge_no >= d0) begin
        if (m_msip == '0) begin
          m_done = 1; m_active = 0;
        end else if (m_to != 0 && (edge_no - d0) == m_to - 1) begin
          m_done = 1; m_active = 0;
          if (nm != '0) begin
            m_err = 1; m_errcl = 4'(lowest_pending(nm)); nm = '0;
          end
        end
      end
    end else if (cmd_valid) begin
      m_err = 0;
      if (cmd_mask == '0) begin
        m_done = 1;
      end else begin
        m_active = 1; m_h = edge_no; m_g = int'(cmd_gap); m_to = int'(cmd_timeout);
        m_sel.delete();
        for (int c = 0; c < NC; c++) if (cmd_mask[c]) m_sel.push_back(c);
        nm |= cl_bits(m_sel[0]);
      end
    end
    m_msip = nm;
    if (!rst) m_busy = m_active || m_done;
    edge_no++;
  endtask

  task automatic check();
    n_vec++;
    assert (msip === m_msip) else begin
      n_err++; $error("FAIL msip: got %h exp %h", msip, m_msip);
    end
    n_vec++;
    assert (done === m_done) else begin
      n_err++; $error("FAIL done: got %b exp %b", done, m_done);
    end
    n_vec++;
    assert (busy === m_busy) else begin
      n_err++; $error("FAIL busy: got %b exp %b", busy, m_busy);
    end
    n_vec++;
    assert (err === m_err) else begin
      n_err++; $error("FAIL err: got %b exp %b", err, m_err);
    end
    n_vec++;
    assert (err_cluster === m_errcl) else begin
      n_err++; $error("FAIL err_cluster: got %0d exp %0d", err_cluster, m_errcl);
    end
    n_vec++;
    assert (cmd_ready === !m_active) else begin
      n_err++; $error("FAIL cmd_ready: got %b exp %b", cmd_ready, !m_active);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
      check();
    end
  endtask

  task automatic issue(input logic [NC-1:0] mask, input logic [7:0] gap,
                       input logic [15:0] to);
    cmd_valid = 1'b1; cmd_mask = mask; cmd_gap = gap; cmd_timeout = to;
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int k;
    // Reset state
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // Two clusters with gap 3; valid held while busy must be ignored
    issue(16'h0005, 8'd3, 16'd0);
    cmd_valid = 1'b1; cmd_mask = 16'hFFFF;
    cyc(3);
    cmd_valid = 1'b0;
    cyc(5);
    msip_clr = cl_bits(0) | cl_bits(2);
    cyc(1);
    msip_clr = '0;
    cyc(3);

    // All clusters back-to-back with gap 0
    issue(16'hFFFF, 8'd0, 16'd0);
    cyc(16);
    msip_clr = '1;
    cyc(1);
    msip_clr = '0;
    cyc(3);

    // Timeout with no acks, then a zero-mask command clears err
    issue(16'h0100, 8'd0, 16'd50);
    cyc(60);
    issue(16'h0000, 8'd0, 16'd0);
    cyc(3);

    // Set/clear collision on cluster 3 hart 0 during its raise
    issue(16'h0009, 8'd2, 16'd0);
    cyc(2);
    msip_clr = '0; msip_clr[3*NR] = 1'b1;
    cyc(1);
    msip_clr = '0;
    cyc(4);
    msip_clr = cl_bits(0) | cl_bits(3);
    cyc(1);
    msip_clr = '0;
    cyc(3);

    // Reset while in the gap after clusters 0 and 1 are raised
    issue(16'h0007, 8'd5, 16'd0);
    cyc(8);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);

    // Clear coinciding with the timeout cycle is a success
    issue(16'h0001, 8'd0, 16'd10);
    cyc(10);
    msip_clr = cl_bits(0);
    cyc(1);
    msip_clr = '0;
    cyc(3);

    // Partial ack before timeout reports the remaining lowest cluster
    issue(16'h0030, 8'd0, 16'd8);
    cyc(3);
    msip_clr = cl_bits(4);
    cyc(1);
    msip_clr = '0;
    cyc(12);

    // Randomized commands with random acks
    for (int t = 0; t < 40; t++) begin
      logic [NC-1:0] rm;
      rm = NC'($urandom) & NC'($urandom);
      issue(rm, 8'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 40)));
      k = 0;
      while (m_active && k < 1500) begin
        msip_clr = '0;
        if ($urandom_range(0, 2) == 0) msip_clr |= cl_bits(int'($urandom_range(0, NC - 1)));
        if ($urandom_range(0, 3) == 0) msip_clr[$urandom_range(0, H - 1)] = 1'b1;
        cmd_valid = ($urandom_range(0, 7) == 0);
        cmd_mask  = NC'($urandom);
        cyc(1);
        k++;
      end
      cmd_valid = 1'b0;
      msip_clr  = '0;
      if (k >= 1500) begin
        n_vec++; n_err++;
        $error("FAIL drain_bound: got active after %0d cycles exp idle", k);
      end
      cyc(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
